// File: rtl/ula_seq.sv
// ula_seq: command sequencer around an external combinational ALU.
// It holds a small register file. It accepts load-immediate and ALU commands through a
// valid/ready handshake, drives the operands to the ALU for one cycle, writes the result
// back, and then pulses done_out.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   cmd_valid_in/ready_out  command handshake (ready only in idle, never during reset)
//   cmd_load_in           1 = load cmd_imm_in into rd, 0 = ALU op
//   cmd_op_in             ALU opcode
//   cmd_rd/rs1/rs2_in     destination and source register indices
//   cmd_imm_in            immediate for loads
//   ula_a/b/op_out        operands and opcode to the external ALU (zero outside OPER)
//   ula_result_in         combinational ALU result
//   done_out              one-cycle completion pulse
//   zero_out              last ALU writeback was zero
//   dbg_sel_in/dbg_data_out  combinational register-file read port
module ula_seq #(
  parameter int unsigned BITS   = 8,
  parameter int unsigned ULA_OP = 3,
  parameter int unsigned REGS   = 4,
  localparam int unsigned IdxW  = (REGS > 1) ? $clog2(REGS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_in,
  output logic              cmd_ready_out,
  input  logic              cmd_load_in,
  input  logic [ULA_OP-1:0] cmd_op_in,
  input  logic [IdxW-1:0]   cmd_rd_in,
  input  logic [IdxW-1:0]   cmd_rs1_in,
  input  logic [IdxW-1:0]   cmd_rs2_in,
  input  logic [BITS-1:0]   cmd_imm_in,
  output logic [BITS-1:0]   ula_a_out,
  output logic [BITS-1:0]   ula_b_out,
  output logic [ULA_OP-1:0] ula_op_out,
  input  logic [BITS-1:0]   ula_result_in,
  output logic              done_out,
  output logic              zero_out,
  input  logic [IdxW-1:0]   dbg_sel_in,
  output logic [BITS-1:0]   dbg_data_out
);

  typedef enum logic [1:0] {StIdle, StOper, StDone} state_e;

  state_e              state_q, state_d;
  logic [BITS-1:0]     regs_q [REGS];
  logic [BITS-1:0]     regs_d [REGS];
  logic [BITS-1:0]     a_q, a_d;
  logic [BITS-1:0]     b_q, b_d;
  logic [ULA_OP-1:0]   op_q, op_d;
  logic [IdxW-1:0]     rd_q, rd_d;
  logic                zero_q, zero_d;
  logic                accept;

  // Ready is masked by rst so nothing is accepted on a reset edge.
  assign cmd_ready_out = (state_q == StIdle) && !rst;
  assign accept        = cmd_valid_in && cmd_ready_out;

  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rd_d    = rd_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (cmd_load_in) begin
            // Loads write on the accept edge and leave zero_q alone.
            regs_d[cmd_rd_in] = cmd_imm_in;
            state_d           = StDone;
          end else begin
            // Operands sampled now, so rd may alias rs1/rs2 and see old values.
            a_d     = regs_q[cmd_rs1_in];
            b_d     = regs_q[cmd_rs2_in];
            op_d    = cmd_op_in;
            rd_d    = cmd_rd_in;
            state_d = StOper;
          end
        end
      end
      StOper: begin
        regs_d[rd_q] = ula_result_in;
        zero_d       = (ula_result_in == '0);
        state_d      = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      regs_q  <= '{default: '0};
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      zero_q  <= zero_d;
    end
  end

  assign ula_a_out    = (state_q == StOper) ? a_q  : '0;
  assign ula_b_out    = (state_q == StOper) ? b_q  : '0;
  assign ula_op_out   = (state_q == StOper) ? op_q : '0;
  // A reset arriving in DONE suppresses the pulse.
  assign done_out     = (state_q == StDone) && !rst;
  assign zero_out     = zero_q;
  assign dbg_data_out = regs_q[dbg_sel_in];

endmodule

// File: tb/tb_ula_seq.sv
module tb_ula_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid_in, cmd_ready_out, cmd_load_in;
  logic [2:0] cmd_op_in;
  logic [1:0] cmd_rd_in, cmd_rs1_in, cmd_rs2_in, dbg_sel_in;
  logic [7:0] cmd_imm_in, ula_a_out, ula_b_out, ula_result_in, dbg_data_out;
  logic [2:0] ula_op_out;
  logic       done_out, zero_out;

  always #5 clk = ~clk;

  ula_seq #(.BITS(8), .ULA_OP(3), .REGS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid_in  (cmd_valid_in),
    .cmd_ready_out (cmd_ready_out),
    .cmd_load_in   (cmd_load_in),
    .cmd_op_in     (cmd_op_in),
    .cmd_rd_in     (cmd_rd_in),
    .cmd_rs1_in    (cmd_rs1_in),
    .cmd_rs2_in    (cmd_rs2_in),
    .cmd_imm_in    (cmd_imm_in),
    .ula_a_out     (ula_a_out),
    .ula_b_out     (ula_b_out),
    .ula_op_out    (ula_op_out),
    .ula_result_in (ula_result_in),
    .done_out      (done_out),
    .zero_out      (zero_out),
    .dbg_sel_in    (dbg_sel_in),
    .dbg_data_out  (dbg_data_out)
  );

  // Reference ALU the sequencer is wired to.
  always_comb begin
    ula_result_in = '0;
    case (ula_op_out)
      3'd0: ula_result_in = ~ula_b_out;
      3'd1: ula_result_in = ula_a_out & ula_b_out;
      3'd2: ula_result_in = ula_a_out | ula_b_out;
      3'd3: ula_result_in = ula_a_out ^ ula_b_out;
      3'd4: ula_result_in = ula_a_out + ula_b_out;
      3'd5: ula_result_in = ula_a_out - ula_b_out;
      3'd6: ula_result_in = ula_a_out << ula_b_out;
      3'd7: ula_result_in = ula_a_out >> ula_b_out;
      default: ula_result_in = '0;
    endcase
  end

  typedef struct packed {
    logic       alu;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] val;
    logic       zero;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] probeq[$];
  logic       probe = 1'b0;
  logic       finished = 1'b0;
  int         n_exp_done = 0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready_out && n < 30);
    if (!cmd_ready_out) begin
      $display("FAIL wait_idle: ready got 0 required 1 within 30 cycles");
      $fatal(1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit ld, input logic [2:0] op, input logic [1:0] rd,
                      input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] imm,
                      input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] val,
                      input bit z, input bit chain, input bit hold);
    exp_t e;
    int   n = 0;
    if (!chain) wait_idle();
    e.alu = !ld; e.a = ea; e.b = eb; e.op = op; e.val = val; e.zero = z;
    sbq.push_back(e);
    n_exp_done++;
    dbg_sel_in   = rd;
    cmd_load_in  = ld;
    cmd_op_in    = op;
    cmd_rd_in    = rd;
    cmd_rs1_in   = rs1;
    cmd_rs2_in   = rs2;
    cmd_imm_in   = imm;
    cmd_valid_in = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready_out && n < 30);
    if (!cmd_ready_out) begin
      $display("FAIL accept: ready got 0 required 1 within 30 cycles");
      $fatal(1);
    end
    @(posedge clk);
    #1;
    if (!hold) cmd_valid_in = 1'b0;
  endtask

  task automatic load(input logic [1:0] rd, input logic [7:0] imm, input bit z);
    send(1'b1, 3'd0, rd, 2'd0, 2'd0, imm, 8'h00, 8'h00, imm, z, 1'b0, 1'b0);
  endtask

  task automatic alu(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                     input logic [1:0] rs2, input logic [7:0] ea, input logic [7:0] eb,
                     input logic [7:0] val, input bit z);
    send(1'b0, op, rd, rs1, rs2, 8'h00, ea, eb, val, z, 1'b0, 1'b0);
  endtask

  task automatic probe_reg(input logic [1:0] idx, input logic [7:0] val);
    @(posedge clk);
    #1;
    dbg_sel_in = idx;
    probeq.push_back(val);
    probe = 1'b1;
    @(posedge clk);
    #1;
    probe = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid_in = 1'b0; cmd_load_in = 1'b0; cmd_op_in = '0;
    cmd_rd_in = '0; cmd_rs1_in = '0; cmd_rs2_in = '0; cmd_imm_in = '0; dbg_sel_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) probe_reg(i[1:0], 8'h00);

    // xor r3 = r1 ^ r2
    load(2'd1, 8'h09, 1'b0);
    load(2'd2, 8'h01, 1'b0);
    alu(3'd3, 2'd3, 2'd1, 2'd2, 8'h09, 8'h01, 8'h08, 1'b0);
    // subtract wrap, zero flag set, loads keep zero flag
    load(2'd1, 8'h00, 1'b0);
    alu(3'd5, 2'd0, 2'd1, 2'd2, 8'h00, 8'h01, 8'hFF, 1'b0);
    alu(3'd5, 2'd3, 2'd2, 2'd2, 8'h01, 8'h01, 8'h00, 1'b1);
    load(2'd3, 8'h05, 1'b1);
    // add overflow, rd aliases sources, shifts
    load(2'd1, 8'hFF, 1'b1);
    alu(3'd4, 2'd1, 2'd1, 2'd1, 8'hFF, 8'hFF, 8'hFE, 1'b0);
    load(2'd2, 8'h02, 1'b0);
    alu(3'd6, 2'd0, 2'd1, 2'd2, 8'hFE, 8'h02, 8'hF8, 1'b0);
    alu(3'd7, 2'd0, 2'd1, 2'd2, 8'hFE, 8'h02, 8'h3F, 1'b0);
    // not / and / or
    alu(3'd0, 2'd0, 2'd1, 2'd2, 8'hFE, 8'h02, 8'hFD, 1'b0);
    alu(3'd1, 2'd1, 2'd1, 2'd0, 8'hFE, 8'hFD, 8'hFC, 1'b0);
    alu(3'd2, 2'd2, 2'd2, 2'd0, 8'h02, 8'hFD, 8'hFF, 1'b0);
    // valid held high across two commands
    send(1'b0, 3'd3, 2'd3, 2'd1, 2'd2, 8'h00, 8'hFC, 8'hFF, 8'h03, 1'b0, 1'b0, 1'b1);
    send(1'b0, 3'd4, 2'd3, 2'd3, 2'd3, 8'h00, 8'h03, 8'h03, 8'h06, 1'b0, 1'b1, 1'b0);
    // reset during OPER aborts the command
    load(2'd1, 8'h10, 1'b0);
    load(2'd2, 8'h20, 1'b0);
    alu(3'd4, 2'd3, 2'd1, 2'd2, 8'h10, 8'h20, 8'h30, 1'b0);
    n_exp_done--;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) probe_reg(i[1:0], 8'h00);
    load(2'd2, 8'h55, 1'b0);
    wait_idle();
    probe_reg(2'd2, 8'h55);
    repeat (2) @(posedge clk);
    finished = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  int   errors = 0;
  int   checks = 0;
  int   n_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  initial begin
    exp_t cur;
    logic in_flight = 1'b0;
    logic oper_chk  = 1'b0;
    logic prev_rst  = 1'b1;
    int   acc_cyc   = 0;
    cur = '0;
    while (!finished) begin
      @(negedge clk);
      if (rst) begin
        chk("done_in_reset", {31'd0, done_out}, 0);
        in_flight = 1'b0;
        oper_chk  = 1'b0;
      end else begin
        if (prev_rst) begin
          chk("ready_after_reset", {31'd0, cmd_ready_out}, 1);
          chk("zero_after_reset", {31'd0, zero_out}, 0);
        end
        if (probe) chk("dbg_read", {24'd0, dbg_data_out}, {24'd0, probeq.pop_front()});
        if (oper_chk) begin
          chk("alu_a", {24'd0, ula_a_out}, cur.alu ? {24'd0, cur.a} : 0);
          chk("alu_b", {24'd0, ula_b_out}, cur.alu ? {24'd0, cur.b} : 0);
          chk("alu_op", {29'd0, ula_op_out}, cur.alu ? {29'd0, cur.op} : 0);
          oper_chk = 1'b0;
        end
        if (done_out) begin
          n_done++;
          chk("done_expected", {31'd0, in_flight}, 1);
          if (in_flight) begin
            chk("latency", cyc - acc_cyc, cur.alu ? 2 : 1);
            chk("writeback", {24'd0, dbg_data_out}, {24'd0, cur.val});
            chk("zero_flag", {31'd0, zero_out}, {31'd0, cur.zero});
          end
          in_flight = 1'b0;
        end else if (in_flight) begin
          chk("ready_busy", {31'd0, cmd_ready_out}, 0);
        end
        if (cmd_valid_in && cmd_ready_out) begin
          chk("accept_expected", sbq.size(), (sbq.size() == 0) ? 1 : sbq.size());
          if (sbq.size() != 0) begin
            cur       = sbq.pop_front();
            in_flight = 1'b1;
            oper_chk  = 1'b1;
            acc_cyc   = cyc;
          end
        end
      end
      prev_rst = rst;
    end
    chk("sb_drained", sbq.size(), 0);
    chk("probe_drained", probeq.size(), 0);
    chk("done_count", n_done, n_exp_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation got no finish required finish before 200000");
    $fatal(1);
  end

endmodule
